truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Sequencer that drives every input combination of an N_IN-input combinational
//  function under test (e.g. the 4-input a/b/c/d function), one vector at a time.
//  Waits a settle interval, then captures the function output into a truth-table register.
//  Start/busy/done handshake; sits between a host or test sequencer and the combinational DUT.
// PARAMETERS
//  N_IN           4   number of DUT inputs; sweeps 2**N_IN vectors
//  SETTLE_CYCLES  1   cycles stim is held before sampling; legal range >=1
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          reset, synchronous, active-low
//  start        in   1          begin sweep; sampled only in IDLE
//  dut_out      in   1          output of combinational DUT
//  expected     in   2**N_IN    golden truth table, bit k = expected out for stim==k
//  stim         out  N_IN       DUT inputs; stim[0]=a, stim[1]=b, stim[2]=c, stim[3]=d
//  busy         out  1          high in SETTLE/SAMPLE
//  done         out  1          one-cycle pulse at sweep end
//  truth_table  out  2**N_IN    captured outputs, bit k = dut_out for stim==k
//  err          out  1          sticky mismatch flag (TT_SWEEP_CHECK_EN)
//  fail_idx     out  N_IN       first failing vector (TT_SWEEP_CHECK_EN)
// BEHAVIOUR
//  Reset (rst_n==0 at clk edge): state=IDLE; stim, truth_table, err, fail_idx=0; busy=done=0.
//  FSM: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
//  IDLE: start=1 -> SETTLE; idx=0, stim=0, wait=0, truth_table=0, err=0, fail_idx=0.
//  SETTLE: wait==SETTLE_CYCLES-1 -> SAMPLE; else wait++.
//  SAMPLE: truth_table[idx] <= dut_out.
//  SAMPLE, idx==2**N_IN-1: -> DONE.
//  SAMPLE, otherwise: idx++, stim<=idx+1, wait=0, -> SETTLE.
//  DONE: done=1 for exactly this cycle; unconditional -> IDLE. start is ignored here.
//  idx counter is N_IN+1 bits wide, so the terminal test never aliases on wrap.
//  stim holds its last value (all ones) after the sweep until the next start.
//  Per vector: SETTLE_CYCLES+1 cycles. start accepted at edge 0 -> done high in cycle
//  1+2**N_IN*(SETTLE_CYCLES+1); this is cycle 33 for the defaults.
//  start while busy: ignored, with no restart and no table clear.
//  Reset mid-sweep: immediate return to reset values. No partial table is retained.
//  truth_table is stable and valid from the done cycle until the next accepted start.
// CONFIGURATION
//  Macro TT_SWEEP_CHECK_EN, defined:
//   - SAMPLE compares dut_out against expected[idx].
//   - First mismatch sets err=1 (sticky until next start or reset) and fail_idx=idx.
//   - Later mismatches do not update fail_idx.
//  Macro TT_SWEEP_CHECK_EN, undefined:
//   - Ports remain present; err and fail_idx are tied 0; expected is unused.
// STRUCTURE
//  Package tt_sweep_pkg: state_t enum {IDLE, SETTLE, SAMPLE, DONE}; N_IN_DEF=4.
//  Sub-module tt_settle_timer: load/count/expire counter sized $clog2(SETTLE_CYCLES+1).
//  FSM, idx counter and capture register live in the top module.
// TESTING (bench models DUT as out = truth_table_ref[stim], combinational)
//  1. Reset, defaults, ref=16'hA5C3, start pulse:
//     done exactly at cycle 33; truth_table=16'hA5C3; stim visits 0..15 in order.
//  2. start held high through the entire sweep:
//     single sweep only; done once; IDLE accepts a new sweep on the cycle after DONE.
//  3. rst_n=0 at vector 7 mid-sweep:
//     next cycle busy=0, stim=0, truth_table=0; a new start gives a full correct sweep.
//  4. SETTLE_CYCLES=3, ref=16'hFFFF:
//     done at cycle 1+16*4=65; truth_table=16'hFFFF.
//  5. CHECK_EN, ref=16'h00F0, expected=16'h00B0:
//     err=1 from the SAMPLE of vector 6; fail_idx=6; unchanged at done.
//  6. CHECK_EN, expected==ref:
//     err=0; fail_idx=0. Without the macro, for any stimulus: err=0 always.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared types for the truth-table sweeper.
// Holds the FSM state encoding and the default input count.
package tt_sweep_pkg;

  localparam int N_IN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-interval counter: load clears it, count advances it.
// expire_o is high once SETTLE_CYCLES-1 is reached.
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(SETTLE_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (count_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2**N_IN input vectors of a combinational DUT and captures its output.
// Define TT_SWEEP_CHECK_EN to compare against the golden table (err/fail_idx).
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int N_IN          = N_IN_DEF,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dut_out,
  input  logic [2**N_IN-1:0] expected,
  output logic [N_IN-1:0]   stim,
  output logic              busy,
  output logic              done,
  output logic [2**N_IN-1:0] truth_table,
  output logic              err,
  output logic [N_IN-1:0]   fail_idx
);

  localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(2**N_IN - 1);

  state_t              state_q, state_d;
  logic [N_IN:0]       idx_q, idx_d;
  logic [N_IN-1:0]     stim_q, stim_d;
  logic [2**N_IN-1:0]  tt_q, tt_d;
  logic                err_q, err_d;
  logic [N_IN-1:0]     fidx_q, fidx_d;
  logic                tmr_load, tmr_count, tmr_expire;

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (tmr_load),
    .count_i (tmr_count),
    .expire_o(tmr_expire)
  );

`ifndef TT_SWEEP_CHECK_EN
  logic unused_expected;
  assign unused_expected = ^expected;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    stim_d    = stim_q;
    tt_d      = tt_q;
    err_d     = err_q;
    fidx_d    = fidx_q;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE;
          idx_d    = '0;
          stim_d   = '0;
          tt_d     = '0;
          err_d    = 1'b0;
          fidx_d   = '0;
          tmr_load = 1'b1;
        end
      end
      SETTLE: begin
        tmr_count = 1'b1;
        if (tmr_expire) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        tt_d[idx_q[N_IN-1:0]] = dut_out;
`ifdef TT_SWEEP_CHECK_EN
        // Only the first mismatch is recorded
        if (!err_q && (dut_out != expected[idx_q[N_IN-1:0]])) begin
          err_d  = 1'b1;
          fidx_d = idx_q[N_IN-1:0];
        end
`endif
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d    = idx_q + 1'b1;
          stim_d   = idx_d[N_IN-1:0];
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      stim_q  <= '0;
      tt_q    <= '0;
      err_q   <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stim_q  <= stim_d;
      tt_q    <= tt_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
    end
  end

  assign stim        = stim_q;
  assign busy        = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done        = (state_q == DONE);
  assign truth_table = tt_q;
  assign err         = err_q;
  assign fail_idx    = fidx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper.
// Two instances: default settle and SETTLE_CYCLES=3.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n1, start1;
  logic [15:0] ref1, exp1;
  logic [3:0]  stim1, fidx1;
  logic        busy1, done1, err1, dut1;
  logic [15:0] tt1;

  logic        rst_n2, start2;
  logic [15:0] ref2, exp2;
  logic [3:0]  stim2, fidx2;
  logic        busy2, done2, err2, dut2;
  logic [15:0] tt2;

  assign dut1 = ref1[stim1];
  assign dut2 = ref2[stim2];

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .start(start1),
    .dut_out(dut1), .expected(exp1), .stim(stim1),
    .busy(busy1), .done(done1), .truth_table(tt1),
    .err(err1), .fail_idx(fidx1)
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n2), .start(start2),
    .dut_out(dut2), .expected(exp2), .stim(stim2),
    .busy(busy2), .done(done2), .truth_table(tt2),
    .err(err2), .fail_idx(fidx2)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on instance 1, follow the sweep until done.
  task automatic sweep1(input logic [15:0] r, input logic [15:0] e,
                        output int dc, output bit sok,
                        output int ecyc);
    int cyc;
    ref1 = r;
    exp1 = e;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    cyc = 1; dc = 0; sok = 1'b1; ecyc = 0;
    while (cyc < 200 && dc == 0) begin
      if (err1 && ecyc == 0) ecyc = cyc;
      if (done1) dc = cyc;
      else if (!busy1 || stim1 != 4'((cyc - 1) / 2)) sok = 1'b0;
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  initial begin
    int  dc, ecyc, cyc, ndone;
    bit  sok, b34, b35;
    rst_n1 = 1'b0; start1 = 1'b0; ref1 = '0; exp1 = '0;
    rst_n2 = 1'b0; start2 = 1'b0; ref2 = '0; exp2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stim", stim1, 0);
    chk("rst_tt", tt1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_err", err1, 0);
    chk("rst_fidx", fidx1, 0);
    rst_n1 = 1'b1; rst_n2 = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic sweep
    sweep1(16'hA5C3, 16'hA5C3, dc, sok, ecyc);
    chk("t1_done_cyc", dc, 33);
    chk("t1_tt", tt1, 16'hA5C3);
    chk("t1_stim_order", sok, 1);
    chk("t1_stim_hold", stim1, 4'hF);
    chk("t1_err", err1, 0);

    // 2: start held high across the whole sweep
    ref1 = 16'h1234; exp1 = 16'h1234;
    start1 = 1'b1;
    @(posedge clk);
    #1 cyc = 1; ndone = 0; dc = 0; b34 = 0; b35 = 0;
    while (cyc <= 35) begin
      if (done1) begin ndone++; dc = cyc; end
      if (cyc == 34) b34 = busy1;
      if (cyc == 35) b35 = busy1;
      @(posedge clk);
      #1 cyc++;
    end
    chk("t2_done_cnt", ndone, 1);
    chk("t2_done_cyc", dc, 33);
    chk("t2_idle_busy", b34, 0);
    chk("t2_restart", b35, 1);
    start1 = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("t2_second_done", done1, 1);
    chk("t2_tt", tt1, 16'h1234);

    // 3: reset at vector 7
    @(posedge clk);
    #1 ref1 = 16'h3C5A; exp1 = 16'h3C5A;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    cyc = 0;
    while (stim1 != 4'd7 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("t3_reach7", stim1, 7);
    rst_n1 = 1'b0;
    @(posedge clk);
    #1;
    chk("t3_busy", busy1, 0);
    chk("t3_stim", stim1, 0);
    chk("t3_tt", tt1, 0);
    rst_n1 = 1'b1;
    @(posedge clk);
    #1;
    sweep1(16'h3C5A, 16'h3C5A, dc, sok, ecyc);
    chk("t3_done_cyc", dc, 33);
    chk("t3_tt_full", tt1, 16'h3C5A);
    chk("t3_stim_order", sok, 1);

    // 4: SETTLE_CYCLES=3
    ref2 = 16'hFFFF; exp2 = 16'hFFFF;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    cyc = 1; dc = 0; sok = 1'b1;
    while (cyc < 300 && dc == 0) begin
      if (done2) dc = cyc;
      else if (!busy2 || stim2 != 4'((cyc - 1) / 4)) sok = 1'b0;
      @(posedge clk);
      #1 cyc++;
    end
    chk("t4_done_cyc", dc, 65);
    chk("t4_tt", tt2, 16'hFFFF);
    chk("t4_stim_order", sok, 1);

    // 5: golden-table mismatch at vector 6
    sweep1(16'h00F0, 16'h00B0, dc, sok, ecyc);
    chk("t5_tt", tt1, 16'h00F0);
`ifdef TT_SWEEP_CHECK_EN
    chk("t5_err", err1, 1);
    chk("t5_fidx", fidx1, 6);
    chk("t5_err_cyc", ecyc, 15);
`else
    chk("t5_err", err1, 0);
    chk("t5_fidx", fidx1, 0);
    chk("t5_err_cyc", ecyc, 0);
`endif

    // 6: golden table equals reference
    sweep1(16'h6996, 16'h6996, dc, sok, ecyc);
    chk("t6_tt", tt1, 16'h6996);
    chk("t6_err", err1, 0);
    chk("t6_fidx", fidx1, 0);
    chk("t6_err_cyc", ecyc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
